axi_ram_slave: RTL and testbench
================================

// Module: axi_ram_slave
// PURPOSE
//  AXI4 slave, BRAM-backed: the responder end of the cache refill/writeback bursts from the arbiter's m_axi port.
//  Sim/FPGA main memory for the core; one transaction in flight, write priority.
// PARAMETERS
//  ADDR_WIDTH   32    byte-address width
//  DEPTH_WORDS  1024  32-bit words in RAM (power of 2); word index = addr[2+:$clog2(DEPTH_WORDS)]
// PORTS
//  clk      in   1   clock
//  rst      in   1   sync active-high reset
//  awaddr   in   ADDR_WIDTH  write burst start byte address
//  awlen    in   8   write beats-1
//  awvalid  in   1   AW valid
//  awready  out  1   AW ready
//  wdata    in   32  write data
//  wstrb    in   4   byte strobes
//  wlast    in   1   last write beat
//  wvalid   in   1   W valid
//  wready   out  1   W ready
//  bresp    out  2   write response
//  bvalid   out  1   B valid
//  bready   in   1   B ready
//  araddr   in   ADDR_WIDTH  read burst start byte address
//  arlen    in   8   read beats-1
//  arvalid  in   1   AR valid
//  arready  out  1   AR ready
//  rdata    out  32  read data
//  rresp    out  2   read response
//  rlast    out  1   last read beat
//  rvalid   out  1   R valid
//  rready   in   1   R ready
// BEHAVIOUR
//  - Only INCR, full-width (4 B) bursts; size/burst/id are not ported. addr[1:0] is ignored.
//  - Reset: all outputs 0; FSM->IDLE; an in-flight burst is dropped with no B/R completion; RAM contents kept.
//  - FSM states: IDLE, W_DATA, W_RESP, R_DATA.
//  - IDLE: awready=arready=1 only when the opposite valid is low or this is AW (write wins on simultaneous AW+AR).
//    AW hs -> latch addr/len, W_DATA. AR hs -> latch, R_DATA.
//  - W_DATA: wready=1. Each W hs writes the wstrb-enabled bytes at the current word, then increments the word.
//    Burst ends on the beat counter reaching awlen (wlast ignored for termination) -> W_RESP.
//  - W_RESP: bvalid=1, bresp held stable until bready; on hs -> IDLE (AR pending is accepted next cycle).
//  - R_DATA: first rvalid exactly 2 cycles after the AR hs edge.
//    With rready held high, 1 beat/cycle (RAM address advances on the R hs).
//    rdata/rlast stable while rvalid & !rready. rlast=1 on beat arlen. Hs on the last beat -> IDLE, rvalid=0 next cycle.
//  - Word index wraps modulo DEPTH_WORDS; the 4 KB boundary is not checked. awlen/arlen=0 is a single beat.
//  - Read/write to the same word in consecutive transactions: read returns the new data (no stale RAM output).
// CONFIGURATION
//  AXI_RAM_SLAVE_DECERR_EN defined: a burst whose start address >= DEPTH_WORDS*4 gets:
//    - writes: all beats accepted and discarded, bresp=2'b11 (DECERR);
//    - reads: every beat rresp=2'b11, rdata=32'h0.
//  Not defined: address wraps, resp always 2'b00 (OKAY).
// STRUCTURE
//  holy_core_pkg: typedef enum axi_slv_state_t {IDLE,W_DATA,W_RESP,R_DATA}; AXI_RESP_OKAY=2'b00, AXI_RESP_DECERR=2'b11.
//  Sub-module axi_slv_bram: single-port sync RAM, 32-bit, 4 byte-enables, 1-cycle read latency.
// TESTING
//  1. rst=1 for 3 cycles mid R burst -> all outputs 0, rvalid never returns until a new AR.
//  2. AW 0x100 len=3, W 0xA0..0xA3 strb=F, bready=1 -> bvalid one cycle after 4th W hs, bresp=0.
//     Then AR 0x100 len=3 -> rdata A0,A1,A2,A3; rlast only on beat 4; first rvalid 2 cycles after AR hs.
//  3. Write 0x11223344 @0x200, then single beat 0x000000FF strb=4'b0001 -> read 0x200 returns 0x112233FF.
//  4. AWVALID and ARVALID rise the same cycle -> awready=1, arready=0; AR accepted the cycle after B hs.
//  5. R burst len=7 with rready toggling 1,0,0,1... -> data held while stalled, 8 beats in order, no loss/duplication.
//  6. DECERR_EN: AR at DEPTH_WORDS*4 len=1 -> 2 beats rresp=3, rdata=0. Without it -> word 0,1 data, rresp=0.

Source files
------------

// File: rtl/holy_core_pkg.sv
// Shared types and response codes for the BRAM-backed AXI4 slave.
// The FSM state encoding lives here so that the RTL and the bench agree on it.
package holy_core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2,
    R_DATA = 2'd3
  } axi_slv_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_slv_bram.sv
// Single-port synchronous RAM: 32-bit words, per-byte write enables, 1-cycle read latency.
// The read register only updates on a read access, so its output holds while en is low.
module axi_slv_bram #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  // NOTE: the storage array and the read register have no reset; contents survive rst.
  logic [31:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 INCR burst slave backed by axi_slv_bram; one transaction in flight, write wins ties.
// Define AXI_RAM_SLAVE_DECERR_EN to answer out-of-range bursts with DECERR instead of wrapping.
module axi_ram_slave
  import holy_core_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  axi_slv_state_t   state_q, state_d;
  logic [IDX_W-1:0] word_q;
  logic [7:0]       beat_q, len_q;
  logic             err_q, rd_wait_q, rvalid_q;
  logic             aw_hs, ar_hs, w_hs, r_hs, last_beat;
  logic             aw_err, ar_err;
  logic             ram_en;
  logic [3:0]       ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_rdata;
  logic             unused_bits;

`ifdef AXI_RAM_SLAVE_DECERR_EN
  assign aw_err = |awaddr[ADDR_WIDTH-1:IDX_W+2];
  assign ar_err = |araddr[ADDR_WIDTH-1:IDX_W+2];
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // Byte offset, out-of-range bits (when wrapping) and wlast do not steer anything.
  assign unused_bits = ^{awaddr[1:0], araddr[1:0], wlast,
                         awaddr[ADDR_WIDTH-1:IDX_W+2], araddr[ADDR_WIDTH-1:IDX_W+2]};

  assign aw_hs     = awvalid && awready;
  assign ar_hs     = arvalid && arready;
  assign w_hs      = wvalid && wready;
  assign r_hs      = rvalid_q && rready;
  assign last_beat = (beat_q == len_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output and next state gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        awready = !rst;
        arready = !rst && !awvalid;
        if (awvalid)      state_d = W_DATA;
        else if (arvalid) state_d = R_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && last_beat) state_d = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      R_DATA: begin
        if (rvalid_q && rready && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      rd_wait_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        word_q <= awaddr[2 +: IDX_W];
        len_q  <= awlen;
        beat_q <= '0;
        err_q  <= aw_err;
      end else if (ar_hs) begin
        word_q    <= araddr[2 +: IDX_W];
        len_q     <= arlen;
        beat_q    <= '0;
        err_q     <= ar_err;
        rd_wait_q <= 1'b1;
      end
      if (w_hs) begin
        word_q <= word_q + IDX_W'(1);
        beat_q <= beat_q + 8'd1;
      end
      if (state_q == R_DATA) begin
        // One settle cycle after AR, then the first RAM read; rvalid follows the read latency.
        rd_wait_q <= 1'b0;
        if (r_hs) begin
          word_q <= word_q + IDX_W'(1);
          beat_q <= beat_q + 8'd1;
          if (last_beat) rvalid_q <= 1'b0;
        end else if (!rvalid_q && !rd_wait_q) begin
          rvalid_q <= 1'b1;
        end
      end
    end
  end

  // Reads prefetch the next word on the R handshake so a held rready gives one beat per cycle.
  assign ram_en   = w_hs ||
                    (state_q == R_DATA && !rd_wait_q && (!rvalid_q || (rready && !last_beat)));
  assign ram_we   = (w_hs && !err_q) ? wstrb : 4'b0000;
  assign ram_addr = (state_q == R_DATA && r_hs) ? word_q + IDX_W'(1) : word_q;

  axi_slv_bram #(.IDX_W(IDX_W)) u_bram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  assign rvalid = rvalid_q;
  assign rdata  = (rvalid_q && !err_q) ? ram_rdata : 32'h0;
  assign rresp  = (rvalid_q && err_q) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
  assign rlast  = rvalid_q && last_beat;
  assign bresp  = (state_q == W_RESP && err_q) ? AXI_RESP_DECERR : AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: drivers push expected B/R responses, a negedge monitor checks them.
// Build with AXI_RAM_SLAVE_DECERR_EN defined to expect DECERR on out-of-range bursts.
module tb_axi_ram_slave;
  import holy_core_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

`ifdef AXI_RAM_SLAVE_DECERR_EN
  localparam bit DECERR_ON = 1'b1;
`else
  localparam bit DECERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic        awready, arready, wready, bvalid, rvalid, rlast;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int     errors = 0;
  int     checks = 0;
  int     rr_mode = 0;
  r_exp_t r_q[$];
  logic [1:0] b_q[$];

  axi_ram_slave dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic exp_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.data = d; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  // rready pattern: 0 = always high, 1 = high one cycle in three, 2 = always low.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        1:       begin rready = (ph == 0); ph = (ph + 1) % 3; end
        2:       begin rready = 1'b0; ph = 0; end
        default: begin rready = 1'b1; ph = 0; end
      endcase
    end
  end

  // Monitor: compares every B and R handshake against the scoreboard queues.
  initial begin
    logic        held_v;
    logic [31:0] held_d;
    logic        held_l;
    r_exp_t      e;
    logic [1:0]  eb;
    held_v = 1'b0; held_d = '0; held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v && rvalid) begin
          check("r_hold_data", rdata, held_d);
          check("r_hold_last", rlast, held_l);
        end
        if (rvalid && rready) begin
          if (r_q.size() == 0) check("r_unexpected_beat", rvalid, 1'b0);
          else begin
            e = r_q.pop_front();
            check("r_data", rdata, e.data);
            check("r_resp", rresp, e.resp);
            check("r_last", rlast, e.last);
          end
        end
        held_v = rvalid && !rready;
        held_d = rdata;
        held_l = rlast;
        if (bvalid && bready) begin
          if (b_q.size() == 0) check("b_unexpected", bvalid, 1'b0);
          else begin
            eb = b_q.pop_front();
            check("b_resp", bresp, eb);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_aw(input logic [31:0] a, input logic [7:0] l);
    int n = 0;
    awaddr = a; awlen = l; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 100) begin @(negedge clk); n++; end
    check("awready", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l);
    int n = 0;
    araddr = a; arlen = l; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    check("arready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 100) begin @(negedge clk); n++; end
    check("wready", wready, 1'b1);
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Burst of base, base+1, ...; bvalid must be up right after the last W handshake.
  task automatic write_seq(input logic [31:0] a, input logic [7:0] l, input logic [31:0] base,
                           input logic [3:0] s, input logic [1:0] resp);
    b_q.push_back(resp);
    send_aw(a, l);
    for (int i = 0; i <= int'(l); i++) send_w(base + 32'(i), s, i == int'(l));
    check("b_latency", bvalid, 1'b1);
  endtask

  task automatic read_seq(input logic [31:0] a, input logic [7:0] l, input logic [31:0] base);
    for (int i = 0; i <= int'(l); i++) exp_r(base + 32'(i), AXI_RESP_OKAY, i == int'(l));
    send_ar(a, l);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && n < 500) begin @(negedge clk); n++; end
    check("drain", 64'(r_q.size() + b_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    // Reset state
    @(negedge clk);
    check("rst_outputs", {awready, arready, wready, bvalid, bresp, rvalid, rdata, rresp, rlast}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_awready", awready, 1'b1);
    check("idle_arready", arready, 1'b1);
    @(posedge clk); #1;

    // Four-beat write then read back, with read latency checks
    write_seq(32'h100, 8'd3, 32'h0000_00A0, 4'hF, AXI_RESP_OKAY);
    wait_idle();
    read_seq(32'h100, 8'd3, 32'h0000_00A0);
    check("r_lat_0", rvalid, 1'b0);
    @(posedge clk); #1;
    check("r_lat_1", rvalid, 1'b0);
    @(posedge clk); #1;
    check("r_lat_2", rvalid, 1'b1);
    wait_idle();

    // Byte-strobe merge
    write_seq(32'h200, 8'd0, 32'h1122_3344, 4'hF, AXI_RESP_OKAY);
    write_seq(32'h200, 8'd0, 32'h0000_00FF, 4'b0001, AXI_RESP_OKAY);
    wait_idle();
    read_seq(32'h200, 8'd0, 32'h1122_33FF);
    wait_idle();

    // Simultaneous AW and AR: write first, AR one cycle after the B handshake
    b_q.push_back(AXI_RESP_OKAY);
    exp_r(32'hCAFE_F00D, AXI_RESP_OKAY, 1'b1);
    awaddr = 32'h300; awlen = 8'd0; awvalid = 1'b1;
    araddr = 32'h300; arlen = 8'd0; arvalid = 1'b1;
    @(negedge clk);
    check("tie_awready", awready, 1'b1);
    check("tie_arready", arready, 1'b0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    send_w(32'hCAFE_F00D, 4'hF, 1'b1);
    check("tie_bvalid", bvalid, 1'b1);
    check("tie_ar_blocked", arready, 1'b0);
    @(posedge clk); #1;
    check("tie_ar_after_b", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_idle();

    // Eight-beat read with rready stalls
    write_seq(32'h400, 8'd7, 32'h5500_0010, 4'hF, AXI_RESP_OKAY);
    wait_idle();
    rr_mode = 1;
    read_seq(32'h400, 8'd7, 32'h5500_0010);
    wait_idle();
    rr_mode = 0;

    // Reset in the middle of a stalled read: no completion afterwards
    rr_mode = 2;
    send_ar(32'h100, 8'd3);
    repeat (2) @(posedge clk);
    #1;
    check("r_before_rst", rvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_outputs", {awready, arready, wready, bvalid, bresp, rvalid, rdata, rresp, rlast}, 64'd0);
    @(posedge clk); #1;
    check("mid_rst_rvalid", rvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    rr_mode = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid) cnt++;
    end
    check("r_after_rst", 64'(cnt), 64'd0);
    @(posedge clk); #1;

    // Out-of-range start address: wrap or DECERR depending on the build
    write_seq(32'h0, 8'd1, 32'h600D_0000, 4'hF, AXI_RESP_OKAY);
    write_seq(32'h1004, 8'd0, 32'h0BAD_BEEF, 4'hF, DECERR_ON ? AXI_RESP_DECERR : AXI_RESP_OKAY);
    wait_idle();
    if (DECERR_ON) begin
      exp_r(32'h0, AXI_RESP_DECERR, 1'b0);
      exp_r(32'h0, AXI_RESP_DECERR, 1'b1);
    end else begin
      exp_r(32'h600D_0000, AXI_RESP_OKAY, 1'b0);
      exp_r(32'h0BAD_BEEF, AXI_RESP_OKAY, 1'b1);
    end
    send_ar(32'h1000, 8'd1);
    wait_idle();
    exp_r(32'h600D_0000, AXI_RESP_OKAY, 1'b0);
    exp_r(DECERR_ON ? 32'h600D_0001 : 32'h0BAD_BEEF, AXI_RESP_OKAY, 1'b1);
    send_ar(32'h0, 8'd1);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
